// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types and helpers for the execute-stage
// multiply/divide engine.
//   md_op_t      - operation encoding presented on the request port
//   md_state_t   - engine FSM states
//   helpers      - op classification and divide iteration count
package muldiv_unit_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MADD  = 4'd2,
    OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4,
    OP_MSUBU = 4'd5,
    OP_DIV   = 4'd6,
    OP_DIVU  = 4'd7
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

  // One quotient bit per iteration.
  function automatic int md_div_cycles(input int width);
    return width;
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic md_is_acc(input md_op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic md_is_sub(input md_op_t op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: restoring unsigned divider, one quotient bit per enabled cycle.
//   clk, resetn      - clock, async active-low reset
//   load             - start: take dividend/divisor and perform the first step
//   step             - perform one further iteration
//   dividend/divisor - unsigned magnitudes, sampled on load
//   quot, rem        - current quotient / partial remainder registers
// After load plus WIDTH-1 steps, quot/rem hold the final unsigned result.
module div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] src_rem, src_quot, dsr_use;
  logic [WIDTH:0]   trial, diff;

  always_comb begin
    // On load the iteration runs on the fresh operands so no cycle is lost.
    src_rem  = load ? '0       : rem_q;
    src_quot = load ? dividend : quot_q;
    dsr_use  = load ? divisor  : dsr_q;
    trial    = {src_rem, src_quot[WIDTH-1]};
    // rem < divisor keeps trial < 2*divisor, so diff[WIDTH] is a clean borrow.
    diff     = trial - {1'b0, dsr_use};
    rem_d    = rem_q;
    quot_d   = quot_q;
    dsr_d    = dsr_use;
    if (load || step) begin
      if (diff[WIDTH]) begin
        rem_d  = trial[WIDTH-1:0];
        quot_d = {src_quot[WIDTH-2:0], 1'b0};
      end else begin
        rem_d  = diff[WIDTH-1:0];
        quot_d = {src_quot[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsr_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsr_q  <= dsr_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: shared multi-cycle multiply / multiply-accumulate / divide.
//   clk, resetn        - clock, async active-low reset
//   flush              - synchronous kill of any in-flight or held operation
//   in_valid/in_ready  - request handshake; op, src_a, src_b, acc_hi, acc_lo
//   out_valid/out_ready- result handshake; res_hi, res_lo
//   busy               - engine not idle
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. in_ready is high only in IDLE, and a request is not taken in a
// flush cycle. out_valid is high only in DONE; res_* then stay constant until
// out_ready is seen high. Divide results: hi = remainder, lo = quotient.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             busy
);

  localparam int W2     = 2 * WIDTH;
  localparam int CNT_W  = $clog2(WIDTH);
  localparam int PIPE_N = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  // The load cycle performs one iteration, so DIV runs the remaining ones.
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(md_div_cycles(WIDTH) - 2);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  // Final multiply stage: sign fix then optional accumulate, modulo 2^(2W).
  function automatic logic [W2-1:0] mul_final(input logic [W2-1:0] prod,
                                               input logic          neg,
                                               input logic [W2-1:0] acc,
                                               input logic          is_acc,
                                               input logic          is_sub);
    logic [W2-1:0] sp;
    sp = neg ? (W2'(0) - prod) : prod;
    if (!is_acc) return sp;
    return is_sub ? (acc - sp) : (acc + sp);
  endfunction

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    res_q, res_d;
  md_op_t           op_q, op_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d, dz_q, dz_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    pipe_q [PIPE_N];
  logic [W2-1:0]    pipe_d [PIPE_N];

  logic             accept, sign_a_in, sign_b_in, is_div_in, div_zero_in;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [W2-1:0]    prod_in, mul_res_in, mul_res_lat, div_res;
  logic [WIDTH-1:0] div_quot, div_rem, quot_s, rem_s;

  assign accept      = in_valid & in_ready & ~flush;
  assign sign_a_in   = md_is_signed(op) & src_a[WIDTH-1];
  assign sign_b_in   = md_is_signed(op) & src_b[WIDTH-1];
  assign mag_a_in    = sign_a_in ? (WIDTH'(0) - src_a) : src_a;
  assign mag_b_in    = sign_b_in ? (WIDTH'(0) - src_b) : src_b;
  assign is_div_in   = md_is_div(op);
  assign div_zero_in = (src_b == '0);
  // Magnitude product; the register chain behind it is left for retiming.
  assign prod_in     = W2'(mag_a_in) * W2'(mag_b_in);

  // Used only when MUL_LAT == 1: the whole multiply completes on accept.
  assign mul_res_in  = mul_final(prod_in, sign_a_in ^ sign_b_in, {acc_hi, acc_lo},
                                 md_is_acc(op), md_is_sub(op));
  assign mul_res_lat = mul_final(pipe_q[PIPE_N-1], sign_a_q ^ sign_b_q, acc_q,
                                 md_is_acc(op_q), md_is_sub(op_q));

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept & is_div_in),
    .step     (state_q == ST_DIV),
    .dividend (mag_a_in),
    .divisor  (mag_b_in),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // Quotient sign is a^b; remainder follows the dividend. INT_MIN / -1 falls
  // out naturally: magnitude 2^(W-1) negates back to itself.
  assign quot_s  = (sign_a_q ^ sign_b_q) ? (WIDTH'(0) - div_quot) : div_quot;
  assign rem_s   = sign_a_q ? (WIDTH'(0) - div_rem) : div_rem;
  assign div_res = dz_q ? {a_raw_q, {WIDTH{1'b1}}} : {rem_s, quot_s};

  // Operation context captured on accept.
  always_comb begin
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    a_raw_d  = a_raw_q;
    acc_d    = acc_q;
    if (accept) begin
      op_d     = op;
      sign_a_d = sign_a_in;
      sign_b_d = sign_b_in;
      dz_d     = is_div_in & div_zero_in;
      a_raw_d  = src_a;
      acc_d    = {acc_hi, acc_lo};
    end
  end

  // Product pipeline: loaded on accept, advanced while in MUL.
  always_comb begin
    for (int i = 0; i < PIPE_N; i++) pipe_d[i] = pipe_q[i];
    if (accept) begin
      pipe_d[0] = prod_in;
    end else if (state_q == ST_MUL) begin
      for (int i = 1; i < PIPE_N; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_div_in) begin
            if (div_zero_in) begin
              state_d = ST_FIX;
            end else begin
              state_d = ST_DIV;
              cnt_d   = DIV_CNT_INIT;
            end
          end else if (MUL_LAT == 1) begin
            state_d = ST_DONE;
            res_d   = mul_res_in;
          end else begin
            state_d = ST_MUL;
            cnt_d   = MUL_CNT_INIT;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          res_d   = mul_res_lat;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DIV: begin
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        res_d   = div_res;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush wins: no DONE entry, so the held result is not touched.
    if (flush) begin
      state_d = ST_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      a_raw_q  <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      a_raw_q  <= a_raw_d;
      acc_q    <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign res_hi    = res_q[W2-1:WIDTH];
  assign res_lo    = res_q[WIDTH-1:0];

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_LAT=2).
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  md_op_t      op;
  logic [31:0] src_a, src_b, acc_hi, acc_lo;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_hi, res_lo;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .acc_hi    (acc_hi),
    .acc_lo    (acc_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ahi, input logic [31:0] alo);
    op       = o;
    src_a    = a;
    src_b    = b;
    acc_hi   = ahi;
    acc_lo   = alo;
    in_valid = 1'b1;
  endtask

  // Issue one op with out_ready high; check latency from accept cycle T,
  // the result, the single-cycle pulse and in_ready returning at T+lat+1.
  task automatic run_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ahi, input logic [31:0] alo,
                        input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input string tag);
    int lat;
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    drive_req(o, a, b, ahi, alo);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_hi"}, res_hi, exp_hi);
    chk({tag, "_lo"}, res_lo, exp_lo);
    tick();
    chk({tag, "_pulse"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pulses;

    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    op        = OP_MULT;
    src_a     = '0;
    src_b     = '0;
    acc_hi    = '0;
    acc_lo    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_hi", res_hi, 0);
    chk("rst_res_lo", res_lo, 0);
    resetn = 1'b1;
    tick();

    // multiplies
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 2,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 2,
           32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(OP_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd0, 2,
           32'h0000_0000, 32'h0000_0006, "mult_negneg");

    // accumulate forms, modulo 2^64
    run_op(OP_MSUBU, 32'd1, 32'd1, 32'h0, 32'h0, 2,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, "msubu_wrap");
    run_op(OP_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 2,
           32'h0000_0001, 32'h0000_0000, "maddu_carry");
    // 5 + (-6) = -1 across the full 64-bit accumulator
    run_op(OP_MADD,  32'hFFFF_FFFE, 32'd3, 32'h0, 32'h5, 2,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, "madd_borrow");
    // 10 - (-6) = 16
    run_op(OP_MSUB,  32'hFFFF_FFFE, 32'd3, 32'h0, 32'hA, 2,
           32'h0000_0000, 32'h0000_0010, "msub_neg");

    // divides (hi = remainder, lo = quotient)
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 33,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 33,
           32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
    run_op(OP_DIVU, 32'd7, 32'd0, 32'd0, 32'd0, 2,
           32'h0000_0007, 32'hFFFF_FFFF, "divu_by0");
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 2,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0_raw");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 33,
           32'h0000_0000, 32'h8000_0000, "div_intmin");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'd0, 32'd0, 33,
           32'h0000_000F, 32'h0FFF_FFFF, "divu_big");

    // flush during a divide, with a new request presented in the flush cycle
    out_ready = 1'b1;
    drive_req(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0);
    tick();                             // now T+1
    in_valid = 1'b0;
    repeat (9) tick();                  // now T+10
    flush = 1'b1;
    drive_req(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd0);
    chk("flush_busy_before", busy, 1);
    tick();                             // now T+11
    flush = 1'b0;
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_ready", in_ready, 1);
    chk("flush_no_valid", out_valid, 0);
    tick();                             // MULTU accepted at T+11, now T+12
    in_valid = 1'b0;
    chk("flush_mul_busy", busy, 1);
    chk("flush_mul_early", out_valid, 0);
    tick();                             // now T+13
    chk("flush_mul_valid", out_valid, 1);
    chk("flush_mul_hi", res_hi, 0);
    chk("flush_mul_lo", res_lo, 42);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
    end
    chk("flush_no_stale", pulses, 0);

    // back-pressure: result held with out_ready low, new request refused
    out_ready = 1'b0;
    drive_req(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("hold_rise", out_valid, 1);
    drive_req(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_hi", res_hi, 0);
      chk("hold_lo", res_lo, 12);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_release", out_valid, 0);
    chk("hold_keep_lo", res_lo, 12);
    chk("hold_ready_back", in_ready, 1);

    // asynchronous reset in the middle of a divide
    drive_req(OP_DIV, 32'd1000, 32'd3, 32'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("midrst_busy", busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy_low", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_res_hi", res_hi, 0);
    chk("midrst_res_lo", res_lo, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
    end
    chk("midrst_no_pulse", pulses, 0);
    run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd0, 2,
           32'h0000_0000, 32'h0000_0006, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
